// File: rtl/cv32e40p_tmr_resync_ctrl.sv
// Recovery sequencer for the triplicated aligner.
// When a voter flags a replica it waits for an instruction boundary, forces a
// resync branch to the voted PC, lets the replicas settle, then re-checks.
// A replica that keeps failing after MAX_RETRY resyncs is reported broken.
// Once two or more replicas are broken the block latches fatal and goes quiet.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no recovery in progress, watching for healthy-replica mismatch
// S_WAIT   | mismatch latched, waiting for boundary / core branch / timeout
// S_RESYNC | single cycle, forced branch to resync_addr_o, IF stalled
// S_SETTLE | IF stalled while replicas reload, error re-evaluated last cycle
// S_CHECK  | single cycle, set_broken_o pulse for an exhausted replica
module cv32e40p_tmr_resync_ctrl #(
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int WAIT_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  block_err_i,
  input  logic [2:0]  is_broken_i,
  input  logic        instr_valid_i,
  input  logic        if_valid_i,
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  output logic        resync_o,
  output logic [31:0] resync_addr_o,
  output logic        stall_o,
  output logic [2:0]  set_broken_o,
  output logic        fatal_o,
  output logic        busy_o
);

  localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_RESYNC = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  state_t          state_q;
  logic [2:0]      mask_q;
  logic [31:0]     addr_q;
  logic [TW-1:0]   wait_tmr_q;
  logic [3:0]      settle_tmr_q;
  logic [2:0][3:0] retry_q;
  logic            resync_q;
  logic            stall_q;
  logic [2:0]      set_broken_q;
  logic            fatal_q;
  logic            busy_q;

  logic [2:0] err;
  logic       boundary;
  logic       fatal_set;
  logic [2:0] retry_max;
  logic [2:0] brk_cand;
  logic [2:0] brk_pick;

  // Error mask, boundary detect and broken-candidate selection
  always_comb begin
    err       = block_err_i & ~is_broken_i;
    boundary  = instr_valid_i & if_valid_i;
    fatal_set = (is_broken_i[0] & is_broken_i[1]) |
                (is_broken_i[0] & is_broken_i[2]) |
                (is_broken_i[1] & is_broken_i[2]);
    for (int i = 0; i < 3; i++) begin
      retry_max[i] = (retry_q[i] == 4'(MAX_RETRY));
    end
    brk_cand = err & mask_q & retry_max;
    // Only the lowest exhausted replica is retired per pass; others retry.
    brk_pick = brk_cand & (~brk_cand + 3'd1);
  end

  // Recovery FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      addr_q       <= '0;
      wait_tmr_q   <= '0;
      settle_tmr_q <= '0;
      retry_q      <= '0;
      resync_q     <= 1'b0;
      stall_q      <= 1'b0;
      set_broken_q <= '0;
      fatal_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      resync_q     <= 1'b0;
      set_broken_q <= '0;
      if (fatal_set) begin
        fatal_q <= 1'b1;
      end
      if (fatal_q || fatal_set) begin
        state_q <= S_IDLE;
        stall_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            for (int i = 0; i < 3; i++) begin
              if (!err[i]) retry_q[i] <= 4'd0;
            end
            if (err != 3'b000) begin
              mask_q     <= err;
              addr_q     <= pc_i;
              wait_tmr_q <= TW'(WAIT_TIMEOUT - 1);
              state_q    <= S_WAIT;
              busy_q     <= 1'b1;
            end
            stall_q <= 1'b0;
          end

          S_WAIT: begin
            if (branch_i) begin
              // The core's own branch flushes all replicas identically.
              settle_tmr_q <= 4'(SETTLE_CYCLES - 1);
              state_q      <= S_SETTLE;
              stall_q      <= 1'b1;
            end else if (boundary) begin
              // Replay from the instruction that was just accepted.
              addr_q   <= pc_i;
              resync_q <= 1'b1;
              stall_q  <= 1'b1;
              state_q  <= S_RESYNC;
            end else if (wait_tmr_q == '0) begin
              resync_q <= 1'b1;
              stall_q  <= 1'b1;
              state_q  <= S_RESYNC;
            end else begin
              wait_tmr_q <= wait_tmr_q - TW'(1);
            end
          end

          S_RESYNC: begin
            for (int i = 0; i < 3; i++) begin
              if (mask_q[i] && !retry_max[i]) retry_q[i] <= retry_q[i] + 4'd1;
            end
            settle_tmr_q <= 4'(SETTLE_CYCLES - 1);
            state_q      <= S_SETTLE;
            stall_q      <= 1'b1;
          end

          S_SETTLE: begin
            if (settle_tmr_q != 4'd0) begin
              settle_tmr_q <= settle_tmr_q - 4'd1;
              mask_q       <= mask_q | err;
            end else if ((err & mask_q) == 3'b000) begin
              state_q <= S_IDLE;
              stall_q <= 1'b0;
              busy_q  <= 1'b0;
            end else if (brk_cand != 3'b000) begin
              for (int i = 0; i < 3; i++) begin
                if (brk_pick[i]) retry_q[i] <= 4'd0;
              end
              set_broken_q <= brk_pick;
              state_q      <= S_CHECK;
              stall_q      <= 1'b0;
            end else begin
              mask_q     <= err;
              addr_q     <= pc_i;
              wait_tmr_q <= TW'(WAIT_TIMEOUT - 1);
              state_q    <= S_WAIT;
              stall_q    <= 1'b0;
            end
          end

          S_CHECK: begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
          end

          default: begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign resync_o      = resync_q;
  assign resync_addr_o = addr_q;
  assign stall_o       = stall_q;
  assign set_broken_o  = set_broken_q;
  assign fatal_o       = fatal_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_cv32e40p_tmr_resync_ctrl.sv
// Directed bench for the TMR resync controller.
module tb_cv32e40p_tmr_resync_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  block_err;
  logic [2:0]  is_broken;
  logic        instr_valid;
  logic        if_valid;
  logic [31:0] pc;
  logic        branch;
  logic        resync;
  logic [31:0] resync_addr;
  logic        stall;
  logic [2:0]  set_broken;
  logic        fatal;
  logic        busy;

  int tests = 0;
  int fails = 0;

  cv32e40p_tmr_resync_ctrl #(
    .MAX_RETRY(3), .SETTLE_CYCLES(2), .WAIT_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .block_err_i(block_err), .is_broken_i(is_broken),
    .instr_valid_i(instr_valid), .if_valid_i(if_valid),
    .pc_i(pc), .branch_i(branch),
    .resync_o(resync), .resync_addr_o(resync_addr), .stall_o(stall),
    .set_broken_o(set_broken), .fatal_o(fatal), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; outputs for the new cycle are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    block_err   = 3'b000;
    is_broken   = 3'b000;
    instr_valid = 1'b0;
    if_valid    = 1'b0;
    pc          = 32'h0;
    branch      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests++;
    if ({resync, resync_addr, stall, set_broken, fatal, busy} !== 39'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {resync, resync_addr, stall, set_broken, fatal, busy});
    end
    rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if (busy !== 1'b0 || stall !== 1'b0 || resync !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%0b stall=%0b resync=%0b expected 0 0 0", busy, stall, resync);
    end
  endtask

  task automatic test_boundary_resync();
    tick(); block_err = 3'b001; pc = 32'h0;                        // t
    tick();                                                        // t+1
    tests++;
    if (busy !== 1'b1 || stall !== 1'b0 || resync !== 1'b0) begin
      fails++;
      $display("FAIL t1_wait_entry: busy=%0b stall=%0b resync=%0b expected 1 0 0", busy, stall, resync);
    end
    tick();                                                        // t+2
    tick(); instr_valid = 1'b1; if_valid = 1'b1; pc = 32'h80;      // t+3
    tests++;
    if (resync !== 1'b0) begin
      fails++;
      $display("FAIL t1_no_early_resync: got %0b expected 0", resync);
    end
    tick(); instr_valid = 1'b0; if_valid = 1'b0; block_err = 3'b000; // t+4
    tests++;
    if (resync !== 1'b1 || resync_addr !== 32'h80 || stall !== 1'b1) begin
      fails++;
      $display("FAIL t1_resync: resync=%0b addr=%0h stall=%0b expected 1 80 1", resync, resync_addr, stall);
    end
    tick();                                                        // t+5
    tests++;
    if (resync !== 1'b0 || stall !== 1'b1) begin
      fails++;
      $display("FAIL t1_settle0: resync=%0b stall=%0b expected 0 1", resync, stall);
    end
    tick();                                                        // t+6
    tests++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL t1_settle1: stall=%0b busy=%0b expected 1 1", stall, busy);
    end
    tick();                                                        // t+7
    tests++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL t1_idle: stall=%0b busy=%0b expected 0 0", stall, busy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_retry_exhaust();
    int n_rs;
    int n_bk;
    int bk_cyc;
    logic [2:0] bk_val;
    n_rs = 0; n_bk = 0; bk_cyc = -1; bk_val = 3'b000;
    tick(); block_err = 3'b010; instr_valid = 1'b1; if_valid = 1'b1; pc = 32'h100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (resync === 1'b1) n_rs++;
      if (set_broken !== 3'b000) begin
        n_bk++;
        bk_val = set_broken;
        bk_cyc = c;
        is_broken = set_broken;
      end
    end
    tests++;
    if (n_rs != 3) begin
      fails++;
      $display("FAIL t2_resync_count: got %0d expected 3", n_rs);
    end
    tests++;
    if (n_bk != 1 || bk_val !== 3'b010) begin
      fails++;
      $display("FAIL t2_broken_pulse: count=%0d value=%b expected 1 010", n_bk, bk_val);
    end
    tests++;
    if (bk_cyc != 13) begin
      fails++;
      $display("FAIL t2_broken_cycle: got %0d expected 13", bk_cyc);
    end
    tests++;
    if (dut.retry_q[1] !== 4'd0) begin
      fails++;
      $display("FAIL t2_retry_cleared: got %0d expected 0", dut.retry_q[1]);
    end
    tests++;
    if (busy !== 1'b0 || fatal !== 1'b0) begin
      fails++;
      $display("FAIL t2_after: busy=%0b fatal=%0b expected 0 0", busy, fatal);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int n_early;
    n_early = 0;
    tick(); block_err = 3'b100; pc = 32'h200;                      // t
    tick(); pc = 32'h300;                                          // t+1
    if (resync === 1'b1) n_early++;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (resync === 1'b1) n_early++;
    end
    tests++;
    if (n_early != 0) begin
      fails++;
      $display("FAIL t3_early_resync: got %0d pulses expected 0", n_early);
    end
    tick(); block_err = 3'b000;                                    // t+17
    tests++;
    if (resync !== 1'b1 || resync_addr !== 32'h200) begin
      fails++;
      $display("FAIL t3_timeout_resync: resync=%0b addr=%0h expected 1 200", resync, resync_addr);
    end
    tick(); tick(); tick(); tick();                                // t+21
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL t3_idle: busy=%0b expected 0", busy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_branch_priority();
    tick(); block_err = 3'b001; pc = 32'h0;                        // t
    tick();                                                        // t+1
    tick(); instr_valid = 1'b1; if_valid = 1'b1; branch = 1'b1; pc = 32'h400; // t+2
    tick(); instr_valid = 1'b0; if_valid = 1'b0; branch = 1'b0; block_err = 3'b000; // t+3
    tests++;
    if (resync !== 1'b0 || stall !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL t4_settle_direct: resync=%0b stall=%0b busy=%0b expected 0 1 1", resync, stall, busy);
    end
    tick();                                                        // t+4
    tests++;
    if (resync !== 1'b0 || stall !== 1'b1) begin
      fails++;
      $display("FAIL t4_settle1: resync=%0b stall=%0b expected 0 1", resync, stall);
    end
    tick();                                                        // t+5
    tests++;
    if (resync !== 1'b0 || stall !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL t4_idle: resync=%0b stall=%0b busy=%0b expected 0 0 0", resync, stall, busy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_fatal();
    int n_act;
    n_act = 0;
    tick(); is_broken = 3'b001;
    tick();
    tests++;
    if (fatal !== 1'b0) begin
      fails++;
      $display("FAIL t5_single_broken: fatal=%0b expected 0", fatal);
    end
    is_broken = 3'b011;
    tick();
    tests++;
    if (fatal !== 1'b1) begin
      fails++;
      $display("FAIL t5_fatal_set: fatal=%0b expected 1", fatal);
    end
    block_err = 3'b100; instr_valid = 1'b1; if_valid = 1'b1; pc = 32'h500;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 5) is_broken = 3'b000;
      if (resync === 1'b1 || stall === 1'b1 || busy === 1'b1) n_act++;
    end
    tests++;
    if (n_act != 0) begin
      fails++;
      $display("FAIL t5_quiet: got %0d active cycles expected 0", n_act);
    end
    tests++;
    if (fatal !== 1'b1) begin
      fails++;
      $display("FAIL t5_sticky: fatal=%0b expected 1", fatal);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_settle();
    int n_bk;
    n_bk = 0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (fatal !== 1'b0) begin
      fails++;
      $display("FAIL t6_fatal_cleared: fatal=%0b expected 0", fatal);
    end
    tick(); block_err = 3'b010; instr_valid = 1'b1; if_valid = 1'b1; pc = 32'h100; // t
    for (int c = 1; c <= 11; c++) tick();                          // t+11: last SETTLE
    tests++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL t6_in_settle: stall=%0b busy=%0b expected 1 1", stall, busy);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({resync, resync_addr, stall, set_broken, fatal, busy} !== 39'd0) begin
      fails++;
      $display("FAIL t6_async_reset: got %0h expected 0",
               {resync, resync_addr, stall, set_broken, fatal, busy});
    end
    tick(); tick();
    idle_inputs();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (set_broken !== 3'b000) n_bk++;
    end
    tests++;
    if (n_bk != 0) begin
      fails++;
      $display("FAIL t6_no_pulse: got %0d pulses expected 0", n_bk);
    end
  endtask

  initial begin
    test_reset();
    test_boundary_resync();
    test_retry_exhaust();
    test_timeout();
    test_branch_priority();
    test_fatal();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
